// File: rtl/frame_rx_deserializer_pkg.sv
// Shared definitions for the serial frame receiver: frame layout, addresses,
// receiver states and small field helpers.
package frame_rx_deserializer_pkg;

  localparam int FRAME_W = 16;
  localparam int BODY_W  = 12;

  localparam logic [3:0] SFD   = 4'b0101;
  localparam logic [3:0] MAC_A = 4'hA;
  localparam logic [3:0] MAC_B = 4'hB;
  localparam logic [3:0] MAC_C = 4'hC;
  localparam logic [3:0] MAC_D = 4'hD;

  localparam int SFD_MSB = 15;
  localparam int SFD_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 8;
  localparam int SRC_MSB = 7;
  localparam int SRC_LSB = 4;
  localparam int PAY_MSB = 3;
  localparam int PAY_LSB = 0;

  // bit_cnt value while the final body bit is being sampled
  localparam logic [3:0] LAST_BODY_BIT = 4'd11;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  function automatic logic [3:0] frame_dst(input logic [FRAME_W-1:0] frame);
    return frame[DST_MSB:DST_LSB];
  endfunction

  function automatic logic dst_accept(input logic [3:0] dst, input logic [3:0] mac,
                                      input logic [3:0] bcast, input logic promisc);
    return promisc || (dst == mac) || (dst == bcast);
  endfunction

endpackage

// File: rtl/frame_rx_deserializer_if.sv
// Serial input and held-frame handshake between the link receiver and its consumer.
interface frame_rx_deserializer_if
  import frame_rx_deserializer_pkg::*;
;
  logic               rx_bit;
  logic               rx_bit_en;
  logic               rx_ready;
  logic               rx_valid;
  logic [FRAME_W-1:0] rx_frame;
  logic [3:0]         rx_src;
  logic [3:0]         rx_payload;

  modport master (
    output rx_bit, rx_bit_en, rx_ready,
    input  rx_valid, rx_frame, rx_src, rx_payload
  );

  modport slave (
    input  rx_bit, rx_bit_en, rx_ready,
    output rx_valid, rx_frame, rx_src, rx_payload
  );

endinterface

// File: rtl/frame_rx_deserializer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module frame_rx_deserializer_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear wins, then increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/frame_rx_deserializer.sv
// Serial frame receiver: hunts for the SFD, deserializes the 12-bit body, filters
// on DST and holds the frame in a one-entry valid/ready output register.
module frame_rx_deserializer
  import frame_rx_deserializer_pkg::*;
#(
  parameter logic [3:0] MAC_ADDRESS = MAC_A,
  parameter logic [3:0] BCAST_ADDR  = 4'hF,
  parameter bit         PROMISC     = 1'b0,
  parameter int         CNT_W       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  frame_rx_deserializer_if.slave    rx_if,
  output logic                      overrun_o,
  output logic [CNT_W-1:0]          cnt_ok_o,
  output logic [CNT_W-1:0]          cnt_filtered_o,
  output logic [CNT_W-1:0]          cnt_overrun_o
);

  state_e             state_q, state_d;
  logic [3:0]         window_q, window_d;
  logic [BODY_W-1:0]  shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic [3:0]         window_shift_s;
  logic               accept_s;
  logic               slot_free_s;
  logic               load_s;
  logic               drop_s;
  logic               check_live_s;

  assign window_shift_s = {window_q[2:0], rx_if.rx_bit};
  assign accept_s       = dst_accept(frame_dst({SFD, shift_q}), MAC_ADDRESS, BCAST_ADDR, PROMISC);
  // the slot counts as free when the held frame is being taken on this very edge
  assign slot_free_s    = !valid_q || rx_if.rx_ready;
  assign load_s         = (state_q == ST_CHECK) && accept_s && slot_free_s;
  assign drop_s         = (state_q == ST_CHECK) && accept_s && !slot_free_s;
  assign check_live_s   = (state_q == ST_CHECK) && !clear_i;

  // next-state: clear aborts everything, otherwise FSM plus output slot update
  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clear_i) begin
      state_d   = ST_HUNT;
      window_d  = 4'b0000;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (valid_q && rx_if.rx_ready) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      case (state_q)
        ST_HUNT: begin
          if (rx_if.rx_bit_en) begin
            window_d = window_shift_s;
            if (window_shift_s == SFD) begin
              state_d   = ST_RECV;
              bit_cnt_d = 4'd0;
            end else begin
              state_d = ST_HUNT;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_RECV: begin
          if (rx_if.rx_bit_en) begin
            shift_d   = {shift_q[BODY_W-2:0], rx_if.rx_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BODY_BIT) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_RECV;
            end
          end else begin
            state_d = ST_RECV;
          end
        end
        ST_CHECK: begin
          state_d  = ST_HUNT;
          window_d = 4'b0000;
          if (load_s) begin
            frame_d = {SFD, shift_q};
            valid_d = 1'b1;
          end else if (drop_s) begin
            overrun_d = 1'b1;
          end else begin
            frame_d = frame_q;
          end
        end
        default: begin
          state_d  = ST_HUNT;
          window_d = 4'b0000;
        end
      endcase
    end
  end

  // state, shift and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_HUNT;
      window_q  <= 4'b0000;
      shift_q   <= {BODY_W{1'b0}};
      bit_cnt_q <= 4'd0;
      frame_q   <= {FRAME_W{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_if.rx_frame   = frame_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_src     = frame_q[SRC_MSB:SRC_LSB];
  assign rx_if.rx_payload = frame_q[PAY_MSB:PAY_LSB];
  assign overrun_o        = overrun_q;

  frame_rx_deserializer_sat_counter #(.W(CNT_W)) u_cnt_ok (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .inc_i  (check_live_s && load_s),
    .count_o(cnt_ok_o)
  );

  frame_rx_deserializer_sat_counter #(.W(CNT_W)) u_cnt_filtered (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .inc_i  (check_live_s && !accept_s),
    .count_o(cnt_filtered_o)
  );

  frame_rx_deserializer_sat_counter #(.W(CNT_W)) u_cnt_overrun (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .inc_i  (check_live_s && drop_s),
    .count_o(cnt_overrun_o)
  );

endmodule

// File: tb/tb_frame_rx_deserializer.sv
// Bench for frame_rx_deserializer: table of single frames, hand-written corner
// sequences, and a randomized stream checked against a stream-level model.
module tb_frame_rx_deserializer;
  import frame_rx_deserializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       overrun;
  logic [7:0] cnt_ok, cnt_filt, cnt_ovr;

  always #5 clk = ~clk;

  frame_rx_deserializer_if rx_if ();

  frame_rx_deserializer #(
    .MAC_ADDRESS(MAC_A), .BCAST_ADDR(4'hF), .PROMISC(1'b0), .CNT_W(8)
  ) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .rx_if         (rx_if.slave),
    .overrun_o     (overrun),
    .cnt_ok_o      (cnt_ok),
    .cnt_filtered_o(cnt_filt),
    .cnt_overrun_o (cnt_ovr)
  );

  typedef struct {
    logic [15:0] frame;
    logic        acc;
  } vec_t;

  typedef struct {
    logic b;
    logic en;
    logic rdy;
  } cyc_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  cyc_t        stim[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock: drive inputs after the falling edge, record a transfer if one will happen
  task automatic cycle(input logic b, input logic en, input logic rdy);
    @(negedge clk);
    rx_if.rx_bit    = b;
    rx_if.rx_bit_en = en;
    rx_if.rx_ready  = rdy;
    #1;
    if (rx_if.rx_valid && rdy) got_q.push_back(rx_if.rx_frame);
  endtask

  task automatic send_frame(input logic [15:0] f, input logic rdy);
    for (int i = 15; i >= 0; i--) cycle(f[i], 1'b1, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    rx_if.rx_bit    = 1'b0;
    rx_if.rx_bit_en = 1'b0;
    rx_if.rx_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
  endtask

  task automatic push_bit(input logic b, input logic rdy_rand);
    if ($urandom_range(0, 3) == 0)
      stim.push_back('{b: 1'($urandom_range(0, 1)), en: 1'b0,
                       rdy: rdy_rand & 1'($urandom_range(0, 1))});
    stim.push_back('{b: b, en: 1'b1, rdy: rdy_rand & 1'($urandom_range(0, 1))});
  endtask

  // Stream model: lock on the first 0101 in the strobed bits (window starts empty),
  // take the next 12 strobed bits as the body, spend one cycle deciding, then hunt again.
  // A held frame leaves the slot on the first cycle after loading where ready is high.
  task automatic run_model(output int e_ok, output int e_filt, output int e_ovr, output logic e_overrun);
    logic [3:0]  win;
    logic [11:0] body;
    logic [3:0]  dst;
    logic        locked, held;
    int          nbits, chk_at, held_t;
    e_ok = 0; e_filt = 0; e_ovr = 0; e_overrun = 1'b0;
    win = 4'h0; body = 12'h000; locked = 1'b0; held = 1'b0;
    nbits = 0; chk_at = -1; held_t = 0;
    exp_q.delete();
    for (int j = 0; j < stim.size(); j++) begin
      if (j == chk_at) begin
        dst = body[11:8];
        if (held) for (int m = held_t + 1; m <= j; m++) if (stim[m].rdy) held = 1'b0;
        if (!(dst == MAC_A || dst == 4'hF)) e_filt++;
        else if (!held) begin
          held = 1'b1; held_t = j; e_ok++;
          exp_q.push_back({SFD, body});
        end else begin
          e_ovr++; e_overrun = 1'b1;
        end
        win = 4'h0; locked = 1'b0; chk_at = -1;
      end else if (stim[j].en) begin
        if (!locked) begin
          win = {win[2:0], stim[j].b};
          if (win == SFD) begin locked = 1'b1; nbits = 0; end
        end else begin
          body = {body[10:0], stim[j].b};
          nbits++;
          if (nbits == 12) chk_at = j + 1;
        end
      end
    end
  endtask

  vec_t        vecs[7];
  int          exp_ok, exp_filt;
  int          m_ok, m_filt, m_ovr;
  logic        m_overrun;
  logic [15:0] f;
  logic [6:0]  noise;

  initial begin
    vecs[0] = '{16'h5AB3, 1'b1};
    vecs[1] = '{16'h5CA7, 1'b0};
    vecs[2] = '{16'h5FD1, 1'b1};
    vecs[3] = '{{SFD, MAC_B, 8'h12}, 1'b0};
    vecs[4] = '{{SFD, MAC_D, 8'h00}, 1'b0};
    vecs[5] = '{16'h5AFF, 1'b1};
    vecs[6] = '{{SFD, MAC_C, 8'h55}, 1'b0};

    do_reset();
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_frame", 32'(rx_if.rx_frame), 32'd0);
    check("rst_src_pay", {24'd0, rx_if.rx_src, rx_if.rx_payload}, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_counters", {8'd0, cnt_ok, cnt_filt, cnt_ovr}, 32'd0);

    // table: single frames with ready high, latency and one-cycle valid pulse
    exp_ok = 0; exp_filt = 0;
    foreach (vecs[k]) begin
      send_frame(vecs[k].frame, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      check("lat_edge_n", 32'(rx_if.rx_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b1);
      check("lat_edge_n1", 32'(rx_if.rx_valid), 32'(vecs[k].acc));
      if (vecs[k].acc) begin
        f = vecs[k].frame;
        check("tbl_frame", 32'(rx_if.rx_frame), 32'(f));
        check("tbl_src", 32'(rx_if.rx_src), 32'(f[7:4]));
        check("tbl_payload", 32'(rx_if.rx_payload), 32'(f[3:0]));
        exp_ok++;
      end else begin
        exp_filt++;
      end
      cycle(1'b0, 1'b0, 1'b1);
      check("pulse_end", 32'(rx_if.rx_valid), 32'd0);
      check("tbl_cnt_ok", 32'(cnt_ok), 32'(exp_ok));
      check("tbl_cnt_filt", 32'(cnt_filt), 32'(exp_filt));
    end

    // overrun with a stalled consumer, then release, then clear of a held frame
    do_reset();
    send_frame(16'h5AB1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("ovr_first_valid", 32'(rx_if.rx_valid), 32'd1);
    send_frame(16'h5AC2, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("ovr_frame_kept", 32'(rx_if.rx_frame), 32'h5AB1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_cnt", 32'(cnt_ovr), 32'd1);
    check("ovr_cnt_ok", 32'(cnt_ok), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("ovr_release_drop", 32'(rx_if.rx_valid), 32'd0);
    send_frame(16'h5AB7, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("clr_pre_valid", 32'(rx_if.rx_valid), 32'd1);
    clear = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    check("clr_valid", 32'(rx_if.rx_valid), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_keep_cnt", {16'd0, cnt_ok, cnt_ovr}, {16'd0, 8'd2, 8'd1});

    // line noise then a frame with the strobe toggling every cycle
    do_reset();
    noise = 7'b0000100;
    for (int i = 6; i >= 0; i--) begin
      cycle(noise[i], 1'b1, 1'b0);
      cycle(~noise[i], 1'b0, 1'b0);
    end
    f = 16'h5AD9;
    for (int i = 15; i >= 0; i--) begin
      cycle(f[i], 1'b1, 1'b0);
      cycle(~f[i], 1'b0, 1'b0);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("strobe_valid", 32'(rx_if.rx_valid), 32'd1);
    check("strobe_frame", 32'(rx_if.rx_frame), 32'h5AD9);

    // reset mid-frame, then a clean frame, then clear during CHECK
    do_reset();
    f = 16'h5AB3;
    for (int i = 15; i >= 9; i--) cycle(f[i], 1'b1, 1'b1);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    check("midrst_valid", 32'(rx_if.rx_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    send_frame(16'h5AB4, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check("midrst_count", 32'(got_q.size()), 32'd1);
    check("midrst_frame", 32'(got_q.size() > 0 ? got_q[0] : 16'h0000), 32'h5AB4);
    check("midrst_cnt_ok", 32'(cnt_ok), 32'd1);
    send_frame(16'h5AB5, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    clear = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    check("chkclr_none", 32'(got_q.size()), 32'd1);
    check("chkclr_cnts", {8'd0, cnt_ok, cnt_filt, cnt_ovr}, {8'd0, 8'd1, 8'd0, 8'd0});
    send_frame(16'h5AB6, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check("chkclr_after", 32'(got_q.size() > 1 ? got_q[1] : 16'h0000), 32'h5AB6);

    // counter saturation
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send_frame({SFD, MAC_A, 8'(n)}, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    check("sat_cnt_ok", 32'(cnt_ok), 32'hFF);
    check("sat_delivered", 32'(got_q.size()), 32'd300);

    // randomized stream against the stream model
    do_reset();
    stim.delete();
    for (int s = 0; s < 40; s++) begin
      logic       rr;
      logic [3:0] d;
      int         sel;
      rr  = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 3);
      for (int i = 0; i < $urandom_range(0, 5); i++) push_bit(1'($urandom_range(0, 1)), rr);
      d = (sel == 0) ? MAC_A : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
      f = {SFD, d, 8'($urandom)};
      for (int i = 15; i >= 0; i--) push_bit(f[i], rr);
    end
    for (int i = 0; i < 20; i++) stim.push_back('{b: 1'b0, en: 1'b0, rdy: 1'b1});
    foreach (stim[j]) cycle(stim[j].b, stim[j].en, stim[j].rdy);
    run_model(m_ok, m_filt, m_ovr, m_overrun);
    check("rnd_delivered", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rnd_frame_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("rnd_cnt_ok", 32'(cnt_ok), 32'(m_ok));
    check("rnd_cnt_filt", 32'(cnt_filt), 32'(m_filt));
    check("rnd_cnt_ovr", 32'(cnt_ovr), 32'(m_ovr));
    check("rnd_overrun", 32'(overrun), 32'(m_overrun));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
